dmem_port_arbiter: RTL
======================

Name: dmem_port_arbiter

Overview:
- Shares the single data-memory port between the pipeline MEM stage (core requester) and an external requester (loader/DMA/debug).
- Core has fixed priority. A starvation counter forces one external access after EXT_MAX_WAIT waiting cycles; the core is stalled for that cycle.
- Sits between the EX/MEM register outputs and datamemory. The core stall output is ORed into the hazard stall chain.

Parameters:
- DATA_W, 32, data width
- DM_ADDRESS, 9, memory byte-address width
- EXT_MAX_WAIT, 8, cycles external may wait before forced grant (min 1)
- WAIT_W, 4, starvation counter width; must hold EXT_MAX_WAIT

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- c_rd  in  1  core read request
- c_wr  in  1  core write request
- c_addr  in  DM_ADDRESS  core address
- c_wdata  in  DATA_W  core write data
- c_funct3  in  3  core access size/sign
- c_rdata  out  DATA_W  core read data, combinational from mem_rdata
- c_stall  out  1  core request not served this cycle
- x_req  in  1  external request valid; held until x_gnt
- x_we  in  1  external write(1)/read(0)
- x_addr  in  DM_ADDRESS  external address
- x_wdata  in  DATA_W  external write data
- x_funct3  in  3  external access size
- x_gnt  out  1  external request accepted this cycle
- x_rvalid  out  1  external read data valid, registered
- x_rdata  out  DATA_W  external read data, registered
- mem_rd  out  1  to datamemory MemRead
- mem_wr  out  1  to datamemory MemWrite
- mem_addr  out  DM_ADDRESS  to datamemory address
- mem_wdata  out  DATA_W  to datamemory write data
- mem_funct3  out  3  to datamemory funct3
- mem_rdata  in  DATA_W  from datamemory, valid same cycle

Behaviour:
- c_act = c_rd | c_wr. Asserting both c_rd and c_wr is illegal; treated as a write.
- FSM states:
  - CORE_PRI: grant core if c_act, else grant external if x_req.
  - EXT_FORCE: grant external unconditionally; c_stall = c_act.
- Transitions:
  - CORE_PRI -> EXT_FORCE when x_req & c_act & wait_cnt == EXT_MAX_WAIT-1 (registered; force takes effect next cycle).
  - EXT_FORCE -> CORE_PRI always after one cycle.
- wait_cnt:
  - +1 each cycle x_req is high and not granted, saturating at EXT_MAX_WAIT-1.
  - Cleared on x_gnt or when x_req is low.
- Dropping x_req in EXT_FORCE (protocol violation): no grant, return to CORE_PRI, mem_rd/mem_wr = 0.
- Mux: mem_* carry the granted requester's fields. With no grant, mem_rd = mem_wr = 0 and mem_addr/wdata/funct3 = 0.
- x_gnt is combinational in the grant cycle. The bench must not change x_* while x_req=1 & x_gnt=0.
- Read response:
  - x_rvalid rises 1 cycle after a granted external read.
  - x_rdata captures mem_rdata in the grant cycle and holds it until the next external read.
  - x_rvalid is 0 after an external write grant.
- c_rdata = mem_rdata always. Valid only when core is granted.
- c_stall = c_act & ~core_granted.
- Back-to-back external requests: granted on consecutive idle-core cycles. x_rvalid may stay high across consecutive reads.
- Reset (async, any time): state = CORE_PRI, wait_cnt = 0, x_rvalid = 0, x_rdata = 0. Combinational outputs follow the inputs. A read in flight during reset is lost with no rvalid.

Optional Feature:
- ARB_PERF_CNT_EN defined: adds outputs perf_core_stalls[31:0] and perf_ext_forced[31:0].
  - perf_core_stalls: +1 each cycle c_stall=1.
  - perf_ext_forced: +1 each EXT_FORCE grant.
  - Both wrap at 2^32 and reset to 0.
- Not defined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Core only: c_rd=1, c_addr=0x010, mem_rdata=0xDEADBEEF -> mem_rd=1, mem_addr=0x010, c_rdata=0xDEADBEEF, c_stall=0, x_gnt=0.
- External only: x_req=1, x_we=0, x_addr=0x020, mem_rdata=0x12345678 -> x_gnt=1 that cycle; next cycle x_rvalid=1, x_rdata=0x12345678.
- Starvation, EXT_MAX_WAIT=8: c_rd held high, x_req held from cycle 0 -> x_gnt=0 for cycles 0-7, x_gnt=1 and c_stall=1 in cycle 8, core granted again in cycle 9.
- Simultaneous, core idle: c_wr=1 and x_req=1 alternating with core idle every other cycle -> external granted on every idle cycle, wait_cnt never reaches force, c_stall never 1.
- Reset mid-force: assert reset asynchronously while in EXT_FORCE -> immediately x_rvalid=0, x_rdata=0; after release, core has priority and wait_cnt restarts at 0.
- ARB_PERF_CNT_EN: rerun starvation scenario 3 times -> perf_ext_forced=3, perf_core_stalls=3.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter: the core has fixed priority, the external requester gets one forced slot
// after EXT_MAX_WAIT waiting cycles. Define ARB_PERF_CNT_EN to add stall/forced-grant counters.
module dmem_port_arbiter #(
    parameter int DATA_W       = 32,
    parameter int DM_ADDRESS   = 9,
    parameter int EXT_MAX_WAIT = 8,
    parameter int WAIT_W       = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  c_rd,
    input  logic                  c_wr,
    input  logic [DM_ADDRESS-1:0] c_addr,
    input  logic [DATA_W-1:0]     c_wdata,
    input  logic [2:0]            c_funct3,
    output logic [DATA_W-1:0]     c_rdata,
    output logic                  c_stall,
    input  logic                  x_req,
    input  logic                  x_we,
    input  logic [DM_ADDRESS-1:0] x_addr,
    input  logic [DATA_W-1:0]     x_wdata,
    input  logic [2:0]            x_funct3,
    output logic                  x_gnt,
    output logic                  x_rvalid,
    output logic [DATA_W-1:0]     x_rdata,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [DM_ADDRESS-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [2:0]            mem_funct3,
    input  logic [DATA_W-1:0]     mem_rdata
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]           perf_core_stalls,
    output logic [31:0]           perf_ext_forced
`endif
);

    typedef enum logic {
        CORE_PRI,
        EXT_FORCE
    } state_t;

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(EXT_MAX_WAIT - 1);

    state_t            state;
    state_t            state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic              c_act;
    logic              core_gnt;
    logic              ext_gnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= CORE_PRI;
        end else begin
            state <= state_next;
        end
    end

    // The forced slot is decided one cycle ahead so the grant itself never depends on wait_cnt.
    always_comb begin
        state_next = CORE_PRI;
        core_gnt   = 1'b0;
        ext_gnt    = 1'b0;
        c_act      = c_rd | c_wr;
        case (state)
            CORE_PRI: begin
                core_gnt = c_act;
                ext_gnt  = x_req & ~c_act;
                if (x_req && c_act && (wait_cnt == WAIT_LAST)) begin
                    state_next = EXT_FORCE;
                end
            end
            EXT_FORCE: begin
                ext_gnt = x_req;
            end
            default: begin
                state_next = CORE_PRI;
            end
        endcase
    end

    // A core request with both strobes set is served as a write.
    always_comb begin
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_funct3 = '0;
        if (core_gnt) begin
            mem_rd     = c_rd & ~c_wr;
            mem_wr     = c_wr;
            mem_addr   = c_addr;
            mem_wdata  = c_wdata;
            mem_funct3 = c_funct3;
        end else if (ext_gnt) begin
            mem_rd     = ~x_we;
            mem_wr     = x_we;
            mem_addr   = x_addr;
            mem_wdata  = x_wdata;
            mem_funct3 = x_funct3;
        end
    end

    assign c_rdata = mem_rdata;
    assign c_stall = c_act & ~core_gnt;
    assign x_gnt   = ext_gnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (!x_req || ext_gnt) begin
            wait_cnt <= '0;
        end else if (wait_cnt != WAIT_LAST) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Read data is captured only on external read grants and held until the next one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_rvalid <= 1'b0;
            x_rdata  <= '0;
        end else begin
            x_rvalid <= ext_gnt & ~x_we;
            if (ext_gnt && !x_we) begin
                x_rdata <= mem_rdata;
            end
        end
    end

`ifdef ARB_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_core_stalls <= '0;
            perf_ext_forced  <= '0;
        end else begin
            if (c_stall) begin
                perf_core_stalls <= perf_core_stalls + 32'd1;
            end
            if ((state == EXT_FORCE) && ext_gnt) begin
                perf_ext_forced <= perf_ext_forced + 32'd1;
            end
        end
    end
`endif

endmodule
